countdown_timer: RTL and testbench

Four-digit MM:SS countdown timer, the down-counting counterpart of the board's stopwatch. The user loads a preset digit by digit with debounced key pulses, starts it, and it counts down once per second to 00:00, then raises `alarm`. It sits at board top level beside the stopwatch. It consumes the same one-cycle debounced key pulses and drives the same four active-low 7-segment displays.

---
 rtl/countdown_pkg.sv | 44 ++++
 rtl/seg7_bcd.sv | 31 +++
 rtl/countdown_timer.sv | 189 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types, digit limits, segment codes and BCD helpers for the MM:SS countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {CD_SET, CD_RUN, CD_PAUSE, CD_DONE} cd_state_t;

    localparam logic [3:0] CD_UNITS_MAX = 4'd9;
    localparam logic [3:0] CD_TENS_MAX  = 4'd5;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [3:0] cd_inc_digit(input logic [3:0] digit, input logic [3:0] limit);
        logic [3:0] result;
        result = (digit >= limit) ? 4'd0 : digit + 4'd1;
        return result;
    endfunction

    // One-second decrement of packed {MM,M,SS,S}; callers never pass 00:00.
    function automatic logic [15:0] cd_decrement(input logic [15:0] packed_time);
        logic [3:0] s;
        logic [3:0] ss;
        logic [3:0] m;
        logic [3:0] mm;
        {mm, m, ss, s} = packed_time;
        if (s != 4'd0) begin
            s = s - 4'd1;
        end else begin
            s = CD_UNITS_MAX;
            if (ss != 4'd0) begin
                ss = ss - 4'd1;
            end else begin
                ss = CD_TENS_MAX;
                if (m != 4'd0) begin
                    m = m - 4'd1;
                end else begin
                    m  = CD_UNITS_MAX;
                    mm = mm - 4'd1;
                end
            end
        end
        return {mm, m, ss, s};
    endfunction

endpackage

// File: rtl/seg7_bcd.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment decoder with a blank override.
module seg7_bcd
    import countdown_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_ZERO;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_ZERO;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = SEG_ZERO;
            endcase
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer driven by debounced key pulses; optional 2 Hz digit blink
// is enabled by defining COUNTDOWN_BLINK_EN.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int IN_CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       key_reset_cleared,
    input  logic       key_start_cleared,
    input  logic       key_set_cleared,
    input  logic       key_inc_cleared,
    output logic [6:0] Hex_0,
    output logic [6:0] Hex_1,
    output logic [6:0] Hex_2,
    output logic [6:0] Hex_3,
    output logic       alarm
);

    localparam int PW = (IN_CLK_HZ > 1) ? $clog2(IN_CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(IN_CLK_HZ - 1);

    cd_state_t   state;
    cd_state_t   state_next;
    logic [3:0]  time_s;
    logic [3:0]  time_ss;
    logic [3:0]  time_m;
    logic [3:0]  time_mm;
    logic [3:0]  time_s_next;
    logic [3:0]  time_ss_next;
    logic [3:0]  time_m_next;
    logic [3:0]  time_mm_next;
    logic [15:0] preset;
    logic [15:0] preset_next;
    logic [1:0]  sel;
    logic [1:0]  sel_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic        alarm_next;

    logic [15:0] time_all;
    logic [15:0] time_dec;
    logic        time_is_zero;
    logic        time_is_one;
    logic        start_act;
    logic        set_act;
    logic        inc_act;
    logic [3:0]  blank;

    assign time_all     = {time_mm, time_m, time_ss, time_s};
    assign time_dec     = cd_decrement(time_all);
    assign time_is_zero = (time_all == 16'h0000);
    assign time_is_one  = (time_all == 16'h0001);

    // Only the highest-priority pulse of a cycle is allowed to act.
    assign start_act = key_start_cleared;
    assign set_act   = key_set_cleared & ~key_start_cleared;
    assign inc_act   = key_inc_cleared & ~key_set_cleared & ~key_start_cleared;

    always_ff @(posedge clk or posedge key_reset_cleared) begin
        if (key_reset_cleared) begin
            state   <= CD_SET;
            time_s  <= 4'd0;
            time_ss <= 4'd0;
            time_m  <= 4'd0;
            time_mm <= 4'd0;
            preset  <= 16'h0000;
            sel     <= 2'd0;
            presc   <= '0;
            alarm   <= 1'b0;
        end else begin
            state   <= state_next;
            time_s  <= time_s_next;
            time_ss <= time_ss_next;
            time_m  <= time_m_next;
            time_mm <= time_mm_next;
            preset  <= preset_next;
            sel     <= sel_next;
            presc   <= presc_next;
            alarm   <= alarm_next;
        end
    end

    always_comb begin
        state_next   = state;
        time_s_next  = time_s;
        time_ss_next = time_ss;
        time_m_next  = time_m;
        time_mm_next = time_mm;
        preset_next  = preset;
        sel_next     = sel;
        presc_next   = presc;

        case (state)
            CD_SET: begin
                if (start_act) begin
                    if (!time_is_zero) begin
                        preset_next = time_all;
                        presc_next  = '0;
                        state_next  = CD_RUN;
                    end
                end else if (set_act) begin
                    sel_next = sel + 2'd1;
                end else if (inc_act) begin
                    case (sel)
                        2'd0:    time_s_next  = cd_inc_digit(time_s, CD_UNITS_MAX);
                        2'd1:    time_ss_next = cd_inc_digit(time_ss, CD_TENS_MAX);
                        2'd2:    time_m_next  = cd_inc_digit(time_m, CD_UNITS_MAX);
                        default: time_mm_next = cd_inc_digit(time_mm, CD_TENS_MAX);
                    endcase
                end
            end
            // A pause landing on a tick keeps the prescaler at its maximum so the
            // discarded decrement happens on the first cycle after resuming.
            CD_RUN: begin
                if (start_act) begin
                    state_next = CD_PAUSE;
                end else if (presc == PRESC_MAX) begin
                    presc_next = '0;
                    {time_mm_next, time_m_next, time_ss_next, time_s_next} = time_dec;
                    if (time_is_one) begin
                        state_next = CD_DONE;
                    end
                end else begin
                    presc_next = presc + 1'b1;
                end
            end
            CD_PAUSE: begin
                if (start_act) begin
                    state_next = CD_RUN;
                end else if (set_act) begin
                    sel_next   = 2'd0;
                    presc_next = '0;
                    state_next = CD_SET;
                end
            end
            CD_DONE: begin
                if (start_act) begin
                    {time_mm_next, time_m_next, time_ss_next, time_s_next} = preset;
                    sel_next   = 2'd0;
                    state_next = CD_SET;
                end
            end
            default: state_next = CD_SET;
        endcase

        alarm_next = (state_next == CD_DONE);
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam int BLINK_DIV = (IN_CLK_HZ / 4 > 1) ? IN_CLK_HZ / 4 : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or posedge key_reset_cleared) begin
        if (key_reset_cleared) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        blank = 4'b0000;
        if (blink_phase) begin
            if (state == CD_DONE) begin
                blank = 4'b1111;
            end else if (state == CD_SET) begin
                blank[sel] = 1'b1;
            end
        end
    end
`else
    assign blank = 4'b0000;
`endif

    seg7_bcd u_seg_0 (.bcd(time_s),  .blank(blank[0]), .seg(Hex_0));
    seg7_bcd u_seg_1 (.bcd(time_ss), .blank(blank[1]), .seg(Hex_1));
    seg7_bcd u_seg_2 (.bcd(time_m),  .blank(blank[2]), .seg(Hex_2));
    seg7_bcd u_seg_3 (.bcd(time_mm), .blank(blank[3]), .seg(Hex_3));

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized bench for countdown_timer against a seconds-based reference model.
module tb_countdown_timer;

    localparam int HZ = 10;
    localparam int Q  = (HZ / 4 > 1) ? HZ / 4 : 1;

    localparam int M_SET   = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk;
    logic       key_reset_cleared;
    logic       key_start_cleared;
    logic       key_set_cleared;
    logic       key_inc_cleared;
    logic [6:0] Hex_0;
    logic [6:0] Hex_1;
    logic [6:0] Hex_2;
    logic [6:0] Hex_3;
    logic       alarm;

    int compared;
    int mismatched;

    // Reference model: the time is a plain count of seconds, not BCD digits.
    int m_mode;
    int m_total;
    int m_preset;
    int m_sel;
    int m_cnt;
    int m_edges;

    logic [6:0] seg_lut [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int weight [0:3] = '{1, 10, 60, 600};

    countdown_timer #(.IN_CLK_HZ(HZ)) dut (
        .clk               (clk),
        .key_reset_cleared (key_reset_cleared),
        .key_start_cleared (key_start_cleared),
        .key_set_cleared   (key_set_cleared),
        .key_inc_cleared   (key_inc_cleared),
        .Hex_0             (Hex_0),
        .Hex_1             (Hex_1),
        .Hex_2             (Hex_2),
        .Hex_3             (Hex_3),
        .alarm             (alarm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int digit_of(input int t, input int idx);
        case (idx)
            0:       return t % 10;
            1:       return (t / 10) % 6;
            2:       return (t / 60) % 10;
            default: return t / 600;
        endcase
    endfunction

    function automatic void model_reset();
        m_mode   = M_SET;
        m_total  = 0;
        m_preset = 0;
        m_sel    = 0;
        m_cnt    = 0;
        m_edges  = 0;
    endfunction

    function automatic void model_inc(input int idx);
        int d;
        int lim;
        int nd;
        d   = digit_of(m_total, idx);
        lim = (idx % 2 == 0) ? 9 : 5;
        nd  = (d == lim) ? 0 : d + 1;
        m_total = m_total + (nd - d) * weight[idx];
    endfunction

    function automatic void model_step(input logic s, input logic t, input logic i);
        m_edges++;
        case (m_mode)
            M_SET: begin
                if (s) begin
                    if (m_total != 0) begin
                        m_preset = m_total;
                        m_cnt    = 0;
                        m_mode   = M_RUN;
                    end
                end else if (t) begin
                    m_sel = (m_sel + 1) % 4;
                end else if (i) begin
                    model_inc(m_sel);
                end
            end
            M_RUN: begin
                if (s) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_cnt++;
                    if (m_cnt == HZ) begin
                        m_cnt = 0;
                        m_total--;
                        if (m_total == 0) m_mode = M_DONE;
                    end
                end
            end
            M_PAUSE: begin
                if (s) begin
                    m_mode = M_RUN;
                end else if (t) begin
                    m_mode = M_SET;
                    m_sel  = 0;
                    m_cnt  = 0;
                end
            end
            default: begin
                if (s) begin
                    m_total = m_preset;
                    m_mode  = M_SET;
                    m_sel   = 0;
                end
            end
        endcase
    endfunction

    function automatic logic [27:0] exp_display();
        logic [27:0] r;
        logic [6:0]  code;
        logic        blank;
        r = '0;
        for (int idx = 0; idx < 4; idx++) begin
            code  = seg_lut[digit_of(m_total, idx)];
            blank = 1'b0;
`ifdef COUNTDOWN_BLINK_EN
            if (((m_edges / Q) % 2) == 1)
                blank = (m_mode == M_DONE) || (m_mode == M_SET && m_sel == idx);
`endif
            if (blank) code = 7'b1111111;
            r[idx*7 +: 7] = code;
        end
        return r;
    endfunction

    task automatic check_output(input string tag);
        logic [27:0] exp_hex;
        logic        exp_alarm;
        exp_hex   = exp_display();
        exp_alarm = (m_mode == M_DONE);
        compared++;
        assert ({Hex_3, Hex_2, Hex_1, Hex_0} === exp_hex) else begin
            mismatched++;
            $error("[TB] FAIL %s hex observed=%h expected=%h", tag, {Hex_3, Hex_2, Hex_1, Hex_0}, exp_hex);
        end
        compared++;
        assert (alarm === exp_alarm) else begin
            mismatched++;
            $error("[TB] FAIL %s alarm observed=%b expected=%b", tag, alarm, exp_alarm);
        end
    endtask

    task automatic check_const(input string tag, input logic [27:0] exp_hex, input logic exp_alarm);
        compared++;
        assert ({Hex_3, Hex_2, Hex_1, Hex_0} === exp_hex) else begin
            mismatched++;
            $error("[TB] FAIL %s hex observed=%h expected=%h", tag, {Hex_3, Hex_2, Hex_1, Hex_0}, exp_hex);
        end
        compared++;
        assert (alarm === exp_alarm) else begin
            mismatched++;
            $error("[TB] FAIL %s alarm observed=%b expected=%b", tag, alarm, exp_alarm);
        end
    endtask

    task automatic check_alarm(input string tag, input logic exp_alarm);
        compared++;
        assert (alarm === exp_alarm) else begin
            mismatched++;
            $error("[TB] FAIL %s alarm observed=%b expected=%b", tag, alarm, exp_alarm);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic t, input logic i, input string tag);
        key_start_cleared = s;
        key_set_cleared   = t;
        key_inc_cleared   = i;
        @(posedge clk);
        model_step(s, t, i);
        #1;
        key_start_cleared = 1'b0;
        key_set_cleared   = 1'b0;
        key_inc_cleared   = 1'b0;
        check_output(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        key_reset_cleared = 1'b1;
        #2;
        model_reset();
        check_output(tag);
        @(posedge clk);
        #1;
        key_reset_cleared = 1'b0;
        check_output(tag);
    endtask

    initial begin
        compared          = 0;
        mismatched        = 0;
        key_reset_cleared = 1'b0;
        key_start_cleared = 1'b0;
        key_set_cleared   = 1'b0;
        key_inc_cleared   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("por");

        $display("[TB] reset while running at 01:23");
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1, "load_123");
        apply_stimulus(1'b0, 1'b1, 1'b0, "load_123");
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1, "load_123");
        apply_stimulus(1'b0, 1'b1, 1'b0, "load_123");
        apply_stimulus(1'b0, 1'b0, 1'b1, "load_123");
        apply_stimulus(1'b1, 1'b0, 1'b0, "start_123");
        idle(15, "run_123");
        do_reset("reset_mid_run");
        check_const("reset_mid_run_const", {4{7'b1000000}}, 1'b0);

        $display("[TB] count 00:13 down to alarm");
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1, "load_13");
        apply_stimulus(1'b0, 1'b1, 1'b0, "load_13");
        apply_stimulus(1'b0, 1'b0, 1'b1, "load_13");
        apply_stimulus(1'b1, 1'b0, 1'b0, "start_13");
        idle(10, "run_13");
        check_const("first_tick_0012", {7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100}, 1'b0);
        idle(120, "run_13");
        check_alarm("alarm_at_0000", 1'b1);
        idle(7, "done_13");
        apply_stimulus(1'b1, 1'b0, 1'b0, "ack_13");
        check_alarm("alarm_cleared_13", 1'b0);

        $display("[TB] borrow from 10:00");
        do_reset("reset_borrow");
        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, "sel_mm");
        apply_stimulus(1'b0, 1'b0, 1'b1, "inc_mm");
        apply_stimulus(1'b1, 1'b0, 1'b0, "start_1000");
        idle(10, "run_1000");
        check_const("borrow_0959", {7'b1000000, 7'b0010000, 7'b0010010, 7'b0010000}, 1'b0);

        $display("[TB] pause and resume");
        do_reset("reset_pause");
        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b1, "load_05");
        apply_stimulus(1'b1, 1'b0, 1'b0, "start_05");
        idle(4, "run_05");
        apply_stimulus(1'b1, 1'b0, 1'b0, "pause_05");
        idle(50, "paused_05");
        apply_stimulus(1'b1, 1'b0, 1'b0, "resume_05");
        idle(12, "resumed_05");
        apply_stimulus(1'b1, 1'b0, 1'b0, "pause_05b");
        apply_stimulus(1'b0, 1'b1, 1'b1, "pause_to_set");
        apply_stimulus(1'b0, 1'b0, 1'b1, "edit_after_pause");

        $display("[TB] simultaneous pulses and start at zero");
        do_reset("reset_prio");
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1, "load_02");
        apply_stimulus(1'b1, 1'b0, 1'b1, "start_and_inc");
        idle(10, "run_02");
        apply_stimulus(1'b0, 1'b1, 1'b1, "run_ignores_keys");
        idle(12, "run_02");
        apply_stimulus(1'b1, 1'b0, 1'b0, "ack_02");
        check_alarm("alarm_cleared_02", 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, "set_beats_inc");
        apply_stimulus(1'b0, 1'b0, 1'b1, "inc_ss");
        do_reset("reset_zero");
        apply_stimulus(1'b1, 1'b0, 1'b0, "start_at_zero");
        apply_stimulus(1'b0, 1'b0, 1'b1, "inc_after_zero_start");
        idle(3, "set_idle");

        $display("[TB] randomized pulses");
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 399) == 0)
                do_reset("rand_reset");
            else
                apply_stimulus($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                               $urandom_range(0, 2) == 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
